// File: rtl/regfile_mp_bypass.sv
// ---------------------------------------------------------------------------
// regfile_mp_bypass
//
// Integer register file for the pipelined RISC-V core. It has two registered
// read ports, two write ports, same-cycle write-to-read bypass, an optional
// hard-wired zero register, and a pending-write scoreboard for the ID-stage
// hazard unit.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset (clears storage, reads, busy)
//   rd_en      read enable; 0 holds rdata1/rdata2 (pipeline stall)
//   rs1, rs2   read indices for ports A/B
//   rdata1/2   registered read data, 1-cycle latency, bypassed from writes
//   we0/wa0/wd0  write port 0 (lower priority)
//   we1/wa1/wd1  write port 1 (higher priority)
//   iss_valid  issue strobe: marks iss_rd as pending
//   iss_rd     destination register being issued
//   busy1/2    scoreboard bit of rs1/rs2 (registered state, not bypassed)
//   busy_vec   full scoreboard state
// ---------------------------------------------------------------------------
module regfile_mp_bypass #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd_en,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            busy1,
    output logic            busy2,
    output logic [NREG-1:0] busy_vec
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy_q;
    logic [XLEN-1:0] rd_next1;
    logic [XLEN-1:0] rd_next2;

    // Register 0 is only special when ZERO_REG is set.
    localparam bit HARD_ZERO = (ZERO_REG != 0);

    // -----------------------------------------------------------------------
    // Storage. Port 1 wins when both ports target the same index.
    // NOTE: the storage array is reset here because the architecture requires
    // every register to read 0 after reset; this forces flops rather than a
    // RAM macro, which is acceptable at 32 entries.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (HARD_ZERO && i == 0) begin
                    regs[i] <= '0;
                end else if (we1 && wa1 == AW'(i)) begin
                    regs[i] <= wd1;
                end else if (we0 && wa0 == AW'(i)) begin
                    regs[i] <= wd0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read bypass: the value a read sees is the register after this cycle's
    // writes. Priority: hard zero > port 1 > port 0 > stored value.
    // NOTE: each always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_next1 = regs[rs1];
        if (HARD_ZERO && rs1 == '0) begin
            rd_next1 = '0;
        end else if (we1 && wa1 == rs1) begin
            rd_next1 = wd1;
        end else if (we0 && wa0 == rs1) begin
            rd_next1 = wd0;
        end
    end

    always_comb begin
        rd_next2 = regs[rs2];
        if (HARD_ZERO && rs2 == '0) begin
            rd_next2 = '0;
        end else if (we1 && wa1 == rs2) begin
            rd_next2 = wd1;
        end else if (we0 && wa0 == rs2) begin
            rd_next2 = wd0;
        end
    end

    // Read registers; rd_en=0 holds them through a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (rd_en) begin
            rdata1 <= rd_next1;
            rdata2 <= rd_next2;
        end
    end

    // -----------------------------------------------------------------------
    // Pending-write scoreboard. A same-cycle issue beats a writeback clear to
    // the same index: the issue is a new producer whose result is not back yet.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (HARD_ZERO && i == 0) begin
                    busy_q[i] <= 1'b0;
                end else if (iss_valid && iss_rd == AW'(i)) begin
                    busy_q[i] <= 1'b1;
                end else if ((we0 && wa0 == AW'(i)) || (we1 && wa1 == AW'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Registered state only; the hazard unit folds in live writes itself.
    assign busy_vec = busy_q;
    assign busy1    = busy_q[rs1];
    assign busy2    = busy_q[rs2];

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_bypass
//
// Directed self-checking bench for regfile_mp_bypass with default parameters
// (XLEN=64, NREG=32, AW=5, ZERO_REG=1). Inputs change 1 time unit after a
// rising edge; outputs are checked 1 time unit after the following edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp_bypass;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            rd_en;
    logic [AW-1:0]   rs1, rs2;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            we0, we1;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            busy1, busy2;
    logic [NREG-1:0] busy_vec;

    int tests  = 0;
    int failed = 0;

    regfile_mp_bypass #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en),
        .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy1(busy1), .busy2(busy2), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    initial begin
        reset = 1'b1; rd_en = 1'b0; rs1 = '0; rs2 = '0;
        idle_writes();
        tick();
        tick();
        reset = 1'b0;

        // Reset state, first read.
        rd_en = 1'b1; rs1 = 5'd5; rs2 = 5'd0;
        tick();
        check("reset_rdata1", rdata1, 64'h0);
        check("reset_rdata2", rdata2, 64'h0);
        check("reset_busy_vec", {32'h0, busy_vec}, 64'h0);

        // Port 0 write bypassed into port A, then read back from storage.
        we0 = 1'b1; wa0 = 5'd3; wd0 = 64'hABCD; rs1 = 5'd3;
        tick();
        check("bypass_wr0", rdata1, 64'hABCD);
        check("nonbusy_write_busy", {32'h0, busy_vec}, 64'h0);
        idle_writes();
        tick();
        check("stored_reg3", rdata1, 64'hABCD);

        // Both ports to the same index: port 1 wins (bypass, then storage).
        we0 = 1'b1; wa0 = 5'd7; wd0 = 64'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 64'h22;
        rs2 = 5'd7;
        tick();
        check("dual_write_bypass", rdata2, 64'h22);
        idle_writes();
        tick();
        check("dual_write_stored", rdata2, 64'h22);

        // Register 0 is hard-wired: write and issue are both ignored.
        we1 = 1'b1; wa1 = 5'd0; wd1 = 64'hFFFF;
        iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
        tick();
        check("zero_bypass", rdata1, 64'h0);
        check("zero_busy", {63'h0, busy_vec[0]}, 64'h0);
        idle_writes();
        tick();
        check("zero_stored", rdata1, 64'h0);

        // Scoreboard set, set-beats-clear, then clear.
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        idle_writes();
        rs1 = 5'd9; rs2 = 5'd9;
        #1;
        check("busy_set_vec", {32'h0, busy_vec}, 64'h200);
        check("busy1_set", {63'h0, busy1}, 64'h1);
        check("busy2_set", {63'h0, busy2}, 64'h1);
        iss_valid = 1'b1; iss_rd = 5'd9;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 64'h99;
        tick();
        check("set_beats_clear", {63'h0, busy_vec[9]}, 64'h1);
        check("bypass_reg9", rdata1, 64'h99);
        iss_valid = 1'b0;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 64'h9A;
        tick();
        check("busy_cleared", {32'h0, busy_vec}, 64'h0);
        check("busy1_cleared", {63'h0, busy1}, 64'h0);

        // Read hold during stall while writes continue.
        we0 = 1'b1; wa0 = 5'd4; wd0 = 64'h55; rs1 = 5'd4; rs2 = 5'd3;
        tick();
        check("read_reg4", rdata1, 64'h55);
        check("read_reg3_b", rdata2, 64'hABCD);
        rd_en = 1'b0; wd0 = 64'h66; rs2 = 5'd7;
        tick();
        check("stall_hold_a", rdata1, 64'h55);
        check("stall_hold_b", rdata2, 64'hABCD);
        rd_en = 1'b1; idle_writes();
        tick();
        check("after_stall_a", rdata1, 64'h66);
        check("after_stall_b", rdata2, 64'h22);

        // Mid-stream reset dominates writes, issues and reads.
        iss_valid = 1'b1; iss_rd = 5'd12;
        we0 = 1'b1; wa0 = 5'd5; wd0 = 64'h77;
        rs1 = 5'd5; reset = 1'b1;
        tick();
        check("rst_mid_rdata1", rdata1, 64'h0);
        check("rst_mid_rdata2", rdata2, 64'h0);
        check("rst_mid_busy", {32'h0, busy_vec}, 64'h0);
        reset = 1'b0; idle_writes();
        rs1 = 5'd4; rs2 = 5'd7;
        tick();
        check("rst_storage_reg4", rdata1, 64'h0);
        check("rst_storage_reg7", rdata2, 64'h0);
        rs1 = 5'd5; rs2 = 5'd3;
        tick();
        check("rst_storage_reg5", rdata1, 64'h0);
        check("rst_storage_reg3", rdata2, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/regfile_mp_bypass.md
Name: regfile_mp_bypass

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core.
- Provides 2 registered read ports and 2 write ports, with same-cycle write-to-read bypass and a hard-wired zero register.
- Includes a pending-write scoreboard used by the ID-stage hazard unit.
- Sits between decode (read/issue) and writeback (commit); replaces the single-write-port file.

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers; power of two, min 2.
- AW, 5, register index width; must equal log2(NREG).
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary storage.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  1  read enable; 0 holds both read outputs (pipeline stall).
- rs1  in  AW  read port A index.
- rs2  in  AW  read port B index.
- rdata1  out  XLEN  registered read data A.
- rdata2  out  XLEN  registered read data B.
- we0  in  1  write port 0 enable.
- wa0  in  AW  write port 0 index.
- wd0  in  XLEN  write port 0 data.
- we1  in  1  write port 1 enable (higher priority).
- wa1  in  AW  write port 1 index.
- wd1  in  XLEN  write port 1 data.
- iss_valid  in  1  issue: mark iss_rd pending.
- iss_rd  in  AW  destination register being issued.
- busy1  out  1  pending bit of rs1 (combinational from scoreboard).
- busy2  out  1  pending bit of rs2 (combinational from scoreboard).
- busy_vec  out  NREG  full scoreboard state.

Behaviour:
- Reset (synchronous): all NREG registers cleared to 0. rdata1/rdata2 = 0. busy_vec = 0. Reset dominates every other input in that cycle.
- Write: on posedge with weN=1, Registers[waN] <= wdN.
  - Both ports target the same index: port 1 data wins.
  - With ZERO_REG=1, writes to index 0 are dropped.
- Read latency is 1 cycle. On posedge with rd_en=1, rdataK <= value of rsK after this cycle's writes (bypass).
  - Priority: zero (ZERO_REG=1 and rsK=0) > wd1 if we1 and wa1=rsK > wd0 if we0 and wa0=rsK > stored value.
  - rd_en=0: rdata1/rdata2 hold; writes and the scoreboard still update.
- Scoreboard, per index i, on posedge:
  - set = iss_valid and iss_rd=i.
  - clr = (we0 and wa0=i) or (we1 and wa1=i).
  - set=1 gives busy=1 (set beats a same-cycle clear; this is a new producer). Else clr=1 gives busy=0. Else hold.
  - With ZERO_REG=1, busy_vec[0] is always 0.
- busy1 = busy_vec[rs1], busy2 = busy_vec[rs2]. These reflect registered state and are not bypassed by same-cycle writes. The hazard unit combines them with the write ports itself.
- A write to a non-busy register is legal: it writes and busy stays 0.
- Index arithmetic is unsigned. With NREG = 2^AW there are no out-of-range indices.
- No X propagation: every output is defined from the first cycle after reset.

Test Plan:
- Reset, then rd_en=1, rs1=5, rs2=0 -> next cycle rdata1=0, rdata2=0, busy_vec=0.
- we0=1, wa0=3, wd0=0xABCD, with rs1=3 in the same cycle -> next cycle rdata1=0xABCD (bypass); one cycle later with no write, rdata1 still 0xABCD.
- we0=1, wa0=7, wd0=0x11 and we1=1, wa1=7, wd1=0x22 -> stored and bypassed value 0x22; rs2=7 on the next read returns 0x22.
- we1=1, wa1=0, wd1=0xFFFF with ZERO_REG=1, rs1=0 -> rdata1=0, busy_vec[0]=0.
- iss_valid=1, iss_rd=9 -> busy_vec[9]=1 and busy1=1 when rs1=9. Later, iss_valid=1, iss_rd=9 together with we0=1, wa0=9 -> busy stays 1. Next cycle we0=1, wa0=9 alone -> busy_vec[9]=0.
- rdata1=0x55 from reg 4, then rd_en=0 while we0 writes reg 4=0x66 -> rdata1 stays 0x55. rd_en=1 -> rdata1=0x66. Assert reset mid-stream -> next cycle all rdata, storage and busy are 0.
